// File: rtl/mask_unit_read_pkg.sv
// Shared sizing, FSM state and response word layout for the mask-unit read collector.
// Pure declarations: no latency, no flow control.
// Imported by the interface, the slot and the collector top.
package mask_unit_read_pkg;

    localparam int MUR_LANES      = 4;
    localparam int MUR_DATA_WIDTH = 32;
    localparam int MUR_TAG_WIDTH  = 4;
    localparam int MUR_WIDX_W     = $clog2(MUR_LANES);
    localparam int MUR_OFF_W      = $clog2(MUR_DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    typedef struct packed {
        logic [MUR_DATA_WIDTH-1:0] data;
        logic [MUR_WIDX_W-1:0]     writeIndex;
        logic [MUR_OFF_W-1:0]      dataOffset;
    } resp_t;

endpackage

// File: rtl/mask_unit_read_collector_if.sv
// Bundles the group descriptor, per-lane responses, assembled output and error flag.
// No latency of its own; group and out use valid/ready, responses have no ready.
// slave = collector view, master = environment view.
interface mask_unit_read_collector_if
    import mask_unit_read_pkg::*;
#(
    parameter int LANES      = MUR_LANES,
    parameter int DATA_WIDTH = MUR_DATA_WIDTH,
    parameter int TAG_WIDTH  = MUR_TAG_WIDTH
);
    logic                        group_valid;
    logic                        group_ready;
    logic [LANES-1:0]            group_bits_mask;
    logic [TAG_WIDTH-1:0]        group_bits_tag;

    logic [LANES-1:0]            resp_valid;
    resp_t [LANES-1:0]           resp_bits;

    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*DATA_WIDTH-1:0] out_bits_data;
    logic [LANES-1:0]            out_bits_mask;
    logic [TAG_WIDTH-1:0]        out_bits_tag;

    logic                        error;

    modport slave (
        input  group_valid, group_bits_mask, group_bits_tag,
        input  resp_valid, resp_bits,
        input  out_ready,
        output group_ready,
        output out_valid, out_bits_data, out_bits_mask, out_bits_tag,
        output error
    );

    modport master (
        output group_valid, group_bits_mask, group_bits_tag,
        output resp_valid, resp_bits,
        output out_ready,
        input  group_ready,
        input  out_valid, out_bits_data, out_bits_mask, out_bits_tag,
        input  error
    );

endinterface

// File: rtl/mask_unit_read_slot.sv
// One result slot: holds the byte-aligned read word and its filled bit.
// Write lands on the next rising edge; no backpressure, writes to a filled slot are refused.
// o_dup flags a write request against an already-filled slot in the same cycle.
module mask_unit_read_slot
    import mask_unit_read_pkg::*;
#(
    parameter int DATA_WIDTH = MUR_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic                  i_we,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [MUR_OFF_W-1:0]  i_offset,
    output logic                  o_filled,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_dup
);

    logic                  r_filled;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_aligned;

    // Wanted byte moves down to bit 0; vacated top bytes fill with zeros.
    assign w_aligned = i_data >> {i_offset, 3'b000};
    assign o_dup     = i_we & r_filled;
    assign o_filled  = r_filled;
    assign o_data    = r_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_filled <= 1'b0;
            r_data   <= '0;
        end else if (i_clear) begin
            r_filled <= 1'b0;
            r_data   <= '0;
        end else if (i_we && !r_filled) begin
            r_filled <= 1'b1;
            r_data   <= w_aligned;
        end
    end

endmodule

// File: rtl/mask_unit_read_collector.sv
// Gathers tagged lane read responses into one LANES-slot group and hands it to the mask unit.
// Last expected response in cycle t gives out_valid in t+1; out fire in t gives group_ready in t+1.
// Output held stable under out_ready low; responses have no ready, strays raise a sticky error.
module mask_unit_read_collector
    import mask_unit_read_pkg::*;
#(
    parameter int LANES      = MUR_LANES,
    parameter int DATA_WIDTH = MUR_DATA_WIDTH,
    parameter int TAG_WIDTH  = MUR_TAG_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset,
    mask_unit_read_collector_if.slave  bus
);

    state_t                              r_state;
    logic                                r_group_ready;
    logic                                r_out_valid;
    logic                                r_error;
    logic [LANES-1:0]                    r_mask;
    logic [TAG_WIDTH-1:0]                r_tag;

    logic                                w_collect;
    logic                                w_accept;
    logic                                w_err;
    logic [LANES-1:0][LANES-1:0]         w_hit;
    logic [LANES-1:0]                    w_req;
    logic [LANES-1:0]                    w_stray;
    logic [LANES-1:0]                    w_multi;
    logic [LANES-1:0]                    w_dup;
    logic [LANES-1:0]                    w_filled;
    logic [LANES-1:0]                    w_filled_nxt;
    logic [LANES-1:0][DATA_WIDTH-1:0]    w_sel_data;
    logic [LANES-1:0][MUR_OFF_W-1:0]     w_sel_off;
    logic [LANES-1:0][DATA_WIDTH-1:0]    w_slot_data;

    assign w_collect = (r_state == ST_COLLECT);
    assign w_accept  = (r_state == ST_IDLE) && bus.group_valid;

    // w_hit[i][k]: port k targets slot i this cycle. Lowest k wins a contested slot.
    always_comb begin
        w_hit      = '0;
        w_sel_data = '0;
        w_sel_off  = '0;
        w_req      = '0;
        w_stray    = '0;
        w_multi    = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < LANES; k++) begin
                w_hit[i][k] = bus.resp_valid[k] &&
                              (bus.resp_bits[k].writeIndex == MUR_WIDX_W'(i));
            end
            for (int k = LANES - 1; k >= 0; k--) begin
                if (w_hit[i][k]) begin
                    w_sel_data[i] = bus.resp_bits[k].data;
                    w_sel_off[i]  = bus.resp_bits[k].dataOffset;
                end
            end
            w_multi[i] = (w_hit[i] & (w_hit[i] - 1'b1)) != '0;
            w_req[i]   = w_collect && (|w_hit[i]) && r_mask[i];
            w_stray[i] = w_collect && (|w_hit[i]) && !r_mask[i];
        end
    end

    assign w_filled_nxt = w_filled | w_req;

    assign w_err = (!w_collect && (|bus.resp_valid)) ||
                   (w_collect && ((|w_multi) || (|w_stray) || (|w_dup)));

    for (genvar g = 0; g < LANES; g++) begin : g_slot
        mask_unit_read_slot #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .clock    (clock),
            .reset    (reset),
            .i_clear  (w_accept),
            .i_we     (w_req[g]),
            .i_data   (w_sel_data[g]),
            .i_offset (w_sel_off[g]),
            .o_filled (w_filled[g]),
            .o_data   (w_slot_data[g]),
            .o_dup    (w_dup[g])
        );
        assign bus.out_bits_data[g*DATA_WIDTH +: DATA_WIDTH] = w_slot_data[g];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_group_ready <= 1'b1;
            r_out_valid   <= 1'b0;
            r_mask        <= '0;
            r_tag         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.group_valid) begin
                        r_mask        <= bus.group_bits_mask;
                        r_tag         <= bus.group_bits_tag;
                        r_group_ready <= 1'b0;
                        if (bus.group_bits_mask == '0) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (w_filled_nxt == r_mask) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state       <= ST_IDLE;
                        r_out_valid   <= 1'b0;
                        r_group_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_out_valid   <= 1'b0;
                    r_group_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_error <= 1'b0;
        end else if (w_err) begin
            r_error <= 1'b1;
        end
    end

    assign bus.group_ready   = r_group_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_bits_mask = r_mask;
    assign bus.out_bits_tag  = r_tag;
    assign bus.error         = r_error;

endmodule

// File: tb/tb_mask_unit_read_collector.sv
// Drives directed and random groups into the collector and compares against a group-level model.
module tb_mask_unit_read_collector;
    import mask_unit_read_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mask_unit_read_collector_if bus ();

    mask_unit_read_collector dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: phase 0 waiting for a group, 1 gathering, 2 holding a finished group.
    int          m_ph;
    logic [3:0]  m_mask, m_filled, m_tag;
    logic [31:0] m_data [4];
    logic        m_err;

    logic [3:0]  s_vld;
    logic [31:0] s_dat [4];
    logic [1:0]  s_wi  [4];
    logic [1:0]  s_off [4];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs();
        chk("group_ready", bus.group_ready, m_ph == 0);
        chk("out_valid", bus.out_valid, m_ph == 2);
        chk("error", bus.error, m_err);
        if (m_ph == 2) begin
            chk("out_data", bus.out_bits_data, {m_data[3], m_data[2], m_data[1], m_data[0]});
            chk("out_mask", bus.out_bits_mask, m_mask);
            chk("out_tag", bus.out_bits_tag, m_tag);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_mask = 0; m_filled = 0; m_tag = 0; m_err = 0;
        for (int i = 0; i < 4; i++) m_data[i] = 0;
    endtask

    task automatic model_edge();
        int ph0;
        logic [3:0] nf;
        bit first;
        ph0 = m_ph;
        if (ph0 == 1) begin
            nf = m_filled;
            for (int i = 0; i < 4; i++) begin
                first = 1;
                for (int k = 0; k < 4; k++) begin
                    if (s_vld[k] && s_wi[k] == 2'(i)) begin
                        if (first && m_mask[i] && !m_filled[i]) begin
                            m_data[i] = s_dat[k] >> (8 * s_off[k]);
                            nf[i] = 1'b1;
                        end else begin
                            m_err = 1'b1;
                        end
                        first = 0;
                    end
                end
            end
            m_filled = nf;
            if (nf == m_mask) m_ph = 2;
        end else if (s_vld != 0) begin
            m_err = 1'b1;
        end
        if (ph0 == 0 && bus.group_valid) begin
            m_mask = bus.group_bits_mask;
            m_tag  = bus.group_bits_tag;
            m_filled = 0;
            for (int i = 0; i < 4; i++) m_data[i] = 0;
            m_ph = (bus.group_bits_mask == 0) ? 2 : 1;
        end else if (ph0 == 2 && bus.out_ready) begin
            m_ph = 0;
        end
    endtask

    // Called at a negedge: apply stimulus, clock once, check at the next negedge.
    task automatic step();
        bus.resp_valid = s_vld;
        for (int k = 0; k < 4; k++)
            bus.resp_bits[k] = '{data: s_dat[k], writeIndex: s_wi[k], dataOffset: s_off[k]};
        @(posedge clock);
        model_edge();
        @(negedge clock);
        s_vld = 0;
        bus.resp_valid = 0;
        bus.group_valid = 0;
        check_outs();
    endtask

    task automatic offer(input logic [3:0] mask, input logic [3:0] tag);
        bus.group_valid = 1'b1;
        bus.group_bits_mask = mask;
        bus.group_bits_tag = tag;
        step();
    endtask

    task automatic set_resp(input int k, input logic [1:0] wi, input logic [31:0] d, input logic [1:0] off);
        s_vld[k] = 1'b1; s_wi[k] = wi; s_dat[k] = d; s_off[k] = off;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_group_ready", bus.group_ready, 1'b1);
        chk("rst_out_data", bus.out_bits_data, 128'h0);
        chk("rst_out_mask", bus.out_bits_mask, 4'h0);
        chk("rst_out_tag", bus.out_bits_tag, 4'h0);
        chk("rst_error", bus.error, 1'b0);
        #2 reset = 1'b1;
        @(negedge clock);
        check_outs();
    endtask

    task automatic rand_resp(input bit allow_err);
        logic [3:0] pend;
        bit legal;
        int i;
        pend = m_mask & ~m_filled;
        legal = 0;
        s_vld = 0;
        for (int k = 0; k < 4; k++) begin
            s_dat[k] = $urandom;
            s_off[k] = 2'($urandom_range(3, 0));
            s_wi[k]  = 2'($urandom_range(3, 0));
            if (m_ph == 1 && pend != 0 && $urandom_range(1, 0) == 1) begin
                do i = $urandom_range(3, 0); while (!pend[i]);
                s_wi[k] = 2'(i);
                pend[i] = 1'b0;
                s_vld[k] = 1'b1;
                legal = 1;
            end else if (allow_err && $urandom_range(3, 0) == 0) begin
                s_vld[k] = 1'b1;
            end
        end
        if (m_ph == 1 && !legal && pend != 0) begin
            for (int j = 3; j >= 0; j--) if (pend[j]) i = j;
            s_vld[0] = 1'b1;
            s_wi[0] = 2'(i);
        end
    endtask

    initial begin
        bus.group_valid = 0; bus.group_bits_mask = 0; bus.group_bits_tag = 0;
        bus.resp_valid = 0; bus.resp_bits = '0; bus.out_ready = 0;
        s_vld = 0;
        for (int k = 0; k < 4; k++) begin s_dat[k] = 0; s_wi[k] = 0; s_off[k] = 0; end
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        do_reset();

        // All four slots in one cycle, slot 2 shifted by one byte.
        offer(4'hF, 4'h5);
        set_resp(0, 2'd2, 32'hAABBCCDD, 2'd1);
        set_resp(1, 2'd0, 32'h11111111, 2'd0);
        set_resp(2, 2'd1, 32'h22222222, 2'd0);
        set_resp(3, 2'd3, 32'h33333333, 2'd0);
        step();
        chk("t1_slot2", bus.out_bits_data[95:64], 32'h00AABBCC);
        chk("t1_tag", bus.out_bits_tag, 4'h5);
        drain();

        // Sparse mask, responses on separate cycles, five stall cycles.
        offer(4'b0101, 4'hA);
        set_resp(2, 2'd0, 32'hDEADBEEF, 2'd3);
        step();
        set_resp(1, 2'd2, 32'hCAFEF00D, 2'd2);
        step();
        repeat (5) step();
        drain();

        // Zero mask finishes the cycle after accept.
        offer(4'b0000, 4'h3);
        chk("t5_zero_data", bus.out_bits_data, 128'h0);
        drain();

        // Reset in the middle of gathering discards the partial group.
        offer(4'hF, 4'h7);
        set_resp(0, 2'd0, 32'h0BADF00D, 2'd0);
        set_resp(1, 2'd1, 32'h0BADCAFE, 2'd0);
        step();
        do_reset();
        offer(4'hF, 4'h9);
        for (int k = 0; k < 4; k++) set_resp(k, 2'(k), 32'h01010101 * (k + 1), 2'd0);
        step();
        drain();

        // Two ports on slot 0 in the same cycle: port 1 wins, error sticks.
        offer(4'b0001, 4'h1);
        set_resp(1, 2'd0, 32'd1, 2'd0);
        set_resp(3, 2'd0, 32'd2, 2'd0);
        step();
        chk("t3_slot0", bus.out_bits_data[31:0], 32'd1);
        chk("t3_error", bus.error, 1'b1);
        drain();
        offer(4'b0001, 4'h2);
        set_resp(0, 2'd0, 32'h12345678, 2'd0);
        step();
        drain();
        chk("t3_error_sticky", bus.error, 1'b1);

        // Response to an unexpected slot is dropped; gathering continues.
        do_reset();
        offer(4'b0010, 4'h4);
        set_resp(0, 2'd3, 32'hFFFFFFFF, 2'd0);
        step();
        chk("t4_error", bus.error, 1'b1);
        step();
        set_resp(2, 2'd1, 32'h87654321, 2'd1);
        step();
        drain();

        // Random traffic: clean groups first, then groups with protocol violations.
        do_reset();
        for (int g = 0; g < 160; g++) begin
            bit allow_err;
            int cyc;
            allow_err = (g >= 110);
            if (allow_err && $urandom_range(7, 0) == 0) rand_resp(1);
            offer(4'($urandom), 4'($urandom));
            cyc = 0;
            while (m_ph == 1 && cyc < 40) begin
                rand_resp(allow_err);
                step();
                cyc++;
            end
            if (m_ph == 1) chk("collect_timeout", 1'b1, 1'b0);
            repeat ($urandom_range(3, 0)) begin
                rand_resp(allow_err);
                step();
            end
            drain();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
